riscv_data_mem: RTL

Data-side memory stage for the pipelined RV32I core. It consumes the MEM-stage address, store data and read/write strobes, plus the instruction's funct3, from the datapath. It implements a byte-addressable data RAM with RV32I load/store sizing and a small memory-mapped I/O window: a transmit byte FIFO with valid/ready drain, a free-running cycle counter, and sticky error status. Load data is returned combinationally within the MEM cycle so the datapath's MEM/WB register captures it at the next edge.

---
 rtl/riscv_data_mem.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_data_mem.sv
// rtl/riscv_data_mem.sv - RV32I data memory stage: sized RAM access plus TX FIFO, cycle counter and error MMIO
module riscv_data_mem #(
  parameter int          DEPTH      = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  output logic [31:0] dReadData,
  output logic        mem_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_TXSTAT = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_ERR    = 2'd3;

  logic          access, is_store, is_load;
  logic          f3_ok, in_ram, in_mmio, unmapped, misaligned, acc_ok;
  logic          ram_acc, mmio_acc;
  logic [1:0]    sz, lane, reg_sel;
  logic [AW-1:0] ram_idx;

  always_comb begin
    access   = MemRead | MemWrite;
    is_store = MemWrite;
    is_load  = MemRead & ~MemWrite;
    sz       = func3[1:0];
    lane     = dAddress[1:0];
    reg_sel  = dAddress[3:2];
    ram_idx  = dAddress[AW+1:2];
    case (func3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~is_store;
      default:                f3_ok = 1'b0;
    endcase
    in_ram   = (dAddress[31:AW+2] == '0);
    in_mmio  = (dAddress[31:4] == MMIO_BASE[31:4]);
    unmapped = ~f3_ok | (~in_ram & ~in_mmio);
    // Registers are word-only, so narrow MMIO accesses fall in the misaligned class.
    misaligned = ~unmapped & ((sz == 2'b01 & lane[0]) |
                              (sz == 2'b10 & lane != 2'b00) |
                              (in_mmio & sz != 2'b10));
    acc_ok   = access & ~unmapped & ~misaligned;
    ram_acc  = acc_ok & in_ram;
    mmio_acc = acc_ok & in_mmio;
    mem_err  = access & (unmapped | misaligned);
  end

  // Data RAM: byte-lane write enables, no reset on contents.
  logic [31:0] ram_q [DEPTH];
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;

  always_comb begin
    ram_we    = ram_acc & is_store;
    ram_be    = 4'b0000;
    ram_wdata = dWriteData;
    case (sz)
      2'b00: begin
        ram_be    = 4'b0001 << lane;
        ram_wdata = {4{dWriteData[7:0]}};
      end
      2'b01: begin
        ram_be    = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{dWriteData[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && ram_be[i]) begin
        ram_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  logic [31:0] ram_rword, ram_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ram_rword = ram_q[ram_idx];
    ram_shift = ram_rword >> {lane, 3'b000};
    ld_byte   = ram_shift[7:0];
    ld_half   = lane[1] ? ram_rword[31:16] : ram_rword[15:0];
  end

  // MMIO state
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [2:0]    err_q, err_d;

  logic          fifo_full, fifo_empty, push, push_ok, pop, drop;
  logic [2:0]    err_set, err_clr;
  logic [31:0]   txstat;

  always_comb begin
    fifo_full  = (count_q == FIFO_FULL);
    fifo_empty = (count_q == '0);
    tx_valid   = ~fifo_empty;
    tx_data    = fifo_q[rd_ptr_q];
    pop        = tx_valid & tx_ready;
    push       = mmio_acc & is_store & (reg_sel == REG_TXDATA);
    // A full FIFO still takes a push when the head leaves on the same edge.
    push_ok    = push & (~fifo_full | pop);
    drop       = push & fifo_full & ~pop;

    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = dWriteData[7:0];
      wr_ptr_d         = wr_ptr_q + FW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (mmio_acc && is_store && reg_sel == REG_CYCLE) begin
      cycle_d = '0;
    end else begin
      cycle_d = cycle_q + 32'd1;
    end

    err_set = {drop, access & unmapped, access & misaligned};
    err_clr = (mmio_acc && is_store && reg_sel == REG_ERR) ? dWriteData[2:0] : 3'b000;
    err_d   = (err_q & ~err_clr) | err_set;

    txstat           = '0;
    txstat[0]        = fifo_full;
    txstat[1]        = fifo_empty;
    txstat[CW+1:2]   = count_q;
  end

  always_comb begin
    dReadData = '0;
    if (acc_ok && is_load) begin
      if (in_ram) begin
        case (func3)
          3'b000:  dReadData = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  dReadData = {{16{ld_half[15]}}, ld_half};
          3'b010:  dReadData = ram_rword;
          3'b100:  dReadData = {24'd0, ld_byte};
          3'b101:  dReadData = {16'd0, ld_half};
          default: dReadData = '0;
        endcase
      end else begin
        case (reg_sel)
          REG_TXSTAT: dReadData = txstat;
          REG_CYCLE:  dReadData = cycle_q;
          REG_ERR:    dReadData = {29'd0, err_q};
          default:    dReadData = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cycle_q  <= '0;
      err_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cycle_q  <= cycle_d;
      err_q    <= err_d;
    end
  end

endmodule
